branch_resolution_queue: RTL and testbench
==========================================

BRANCH_RESOLUTION_QUEUE -- requirements
Module: branch_resolution_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of in-flight branch entries; legal range 2..16.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning width of the stored recovery address.
REQ-003 SHALL have parameter META_W, default 2, meaning width of the stored predictor metadata (e.g. counter state / table index).
REQ-004 SHALL have ports: clk  in  1  rising-edge clock.
REQ-005 SHALL have ports: rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports: stall  in  1  freezes all state when high.
REQ-007 SHALL have ports: push_valid  in  1  enqueue request; push_addr  in  ADDR_W  recovery address; push_pred  in  1  predicted direction; push_meta  in  META_W  metadata.
REQ-008 SHALL have ports: push_ready  out  1  enqueue will be accepted this cycle.
REQ-009 SHALL have ports: resolve_valid  in  1  oldest branch resolved this cycle; resolve_taken  in  1  actual direction.
REQ-010 SHALL have ports: head_valid  out  1; head_addr  out  ADDR_W; head_pred  out  1; head_meta  out  META_W  (oldest entry; zero when empty).
REQ-011 SHALL have ports: mispredict  out  1  combinational flush indication; count  out  $clog2(DEPTH+1)  occupancy; full  out  1; empty  out  1.
REQ-012 SHALL have ports: overflow  out  1  sticky dropped-push flag; underflow  out  1  sticky resolve-while-empty flag; mispredict_cnt  out  16  saturating mispredict counter.

Function
REQ-013 SHALL implement a circular FIFO with head and tail pointers that wrap modulo DEPTH, including for non-power-of-two DEPTH.
REQ-014 SHALL assert full when count==DEPTH and empty when count==0.
REQ-015 SHALL drive push_ready = ~stall & (~full | (resolve_valid & ~empty & ~mispredict)).
REQ-016 SHALL drive mispredict = ~stall & resolve_valid & head_valid & (resolve_taken != head_pred), combinationally.
REQ-017 SHALL take no state change on any cycle with stall high; outputs reflect held state.
REQ-018 SHALL, on a correct resolve (resolve_valid, ~empty, no mispredict), pop the head, advance head pointer, and decrement count; the new head is visible the next cycle.
REQ-019 SHALL, on a mispredict, clear all entries, reset both pointers to 0 and count to 0 next cycle, discarding any same-cycle push.
REQ-020 SHALL, on push_valid & push_ready without a mispredict, write the entry at the tail, advance the tail, and increment count.
REQ-021 SHALL, on simultaneous accepted push and correct resolve, pop and push in one cycle with count unchanged, including when full.
REQ-022 SHALL, on simultaneous push and correct resolve with count==0, ignore the resolve as an underflow and accept the push.
REQ-023 SHALL, on push_valid with push_ready low and stall low and no mispredict, drop the entry and set overflow until reset.
REQ-024 SHALL, on resolve_valid while empty and stall low, take no pop and set underflow until reset.
REQ-025 SHALL increment mispredict_cnt by 1 per mispredict, saturating at 16'hFFFF.
REQ-026 SHALL present head fields zero whenever empty; no X on any output after reset.

Reset
REQ-027 SHALL, while rst_n low, asynchronously force pointers, count, all entries, overflow, underflow and mispredict_cnt to 0; empty=1, full=0, head_valid=0, push_ready=0 until stall resolves.
REQ-028 SHALL, on reset asserted mid-operation, discard all in-flight entries; first push after release lands at slot 0.

Verification
REQ-029 SHALL cover fill: DEPTH=4, four pushes addr 0x1000..0x1003 -> count=4, full=1, head_addr=0x1000, push_ready=0.
REQ-030 SHALL cover overflow: full, fifth push without resolve -> entry dropped, overflow=1, count stays 4.
REQ-031 SHALL cover in-order pop and wrap: six push/correct-resolve pairs (pred=1, taken=1) -> head_addr sequence correct across pointer wrap, count never exceeds 4.
REQ-032 SHALL cover mispredict flush: 3 entries, head_pred=0, resolve_taken=1 with same-cycle push -> mispredict=1 that cycle, next cycle count=0, empty=1, mispredict_cnt=1.
REQ-033 SHALL cover full pass-through: full, push 0x2000 with correct resolve -> count=4, old head popped, 0x2000 at tail.
REQ-034 SHALL cover stall and reset: stall high with push and resolve -> no change; rst_n low mid-fill -> count=0, empty=1 immediately, without a clock edge.

Source files
------------

// File: rtl/branch_resolution_queue.sv
// Branch resolution queue: in-order FIFO of in-flight branches holding the
// recovery address, predicted direction and predictor metadata. The oldest
// entry is resolved against the actual direction; a mismatch flushes the queue.
module branch_resolution_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned META_W = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         stall,
   input  logic                         push_valid,
   input  logic [ADDR_W-1:0]            push_addr,
   input  logic                         push_pred,
   input  logic [META_W-1:0]            push_meta,
   output logic                         push_ready,
   input  logic                         resolve_valid,
   input  logic                         resolve_taken,
   output logic                         head_valid,
   output logic [ADDR_W-1:0]            head_addr,
   output logic                         head_pred,
   output logic [META_W-1:0]            head_meta,
   output logic                         mispredict,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic                         overflow,
   output logic                         underflow,
   output logic [15:0]                  mispredict_cnt
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic              pred_mem [DEPTH];
   logic [META_W-1:0] meta_mem [DEPTH];

   logic [PW-1:0] head_ptr;
   logic [PW-1:0] tail_ptr;
   logic [CW-1:0] occ;

   logic pop;
   logic push_acc;
   logic drop;
   logic under;

   // Pointer advance with explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1))
         return '0;
      else
         return p + PW'(1);
   endfunction

   assign count      = occ;
   assign empty      = (occ == '0);
   assign full       = (occ == CW'(DEPTH));
   assign head_valid = ~empty;

   // Head presentation, flush detection and handshake decode.
   always_comb begin
      head_addr  = '0;
      head_pred  = 1'b0;
      head_meta  = '0;
      if (head_valid) begin
         head_addr = addr_mem[head_ptr];
         head_pred = pred_mem[head_ptr];
         head_meta = meta_mem[head_ptr];
      end
      mispredict = ~stall & resolve_valid & head_valid &
                   (resolve_taken != pred_mem[head_ptr]);
      // A correct resolve frees the head slot this cycle, so a full queue
      // can still accept a push; held low while reset is asserted.
      push_ready = rst_n & ~stall &
                   (~full | (resolve_valid & ~empty & ~mispredict));
      pop        = ~stall & resolve_valid & ~empty & ~mispredict;
      push_acc   = push_valid & push_ready & ~mispredict;
      drop       = ~stall & push_valid & ~push_ready & ~mispredict;
      under      = ~stall & resolve_valid & empty;
   end

   // Pointer and occupancy update; a flush returns everything to slot 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         occ      <= '0;
      end else if (!stall) begin
         if (mispredict) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            occ      <= '0;
         end else begin
            if (pop)
               head_ptr <= wrap_inc(head_ptr);
            if (push_acc)
               tail_ptr <= wrap_inc(tail_ptr);
            occ <= occ + CW'(push_acc) - CW'(pop);
         end
      end
   end

   // Entry storage: write at tail on accepted push, wipe on flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_mem[i] <= '0;
            pred_mem[i] <= 1'b0;
            meta_mem[i] <= '0;
         end
      end else if (!stall) begin
         if (mispredict) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               addr_mem[i] <= '0;
               pred_mem[i] <= 1'b0;
               meta_mem[i] <= '0;
            end
         end else if (push_acc) begin
            addr_mem[tail_ptr] <= push_addr;
            pred_mem[tail_ptr] <= push_pred;
            meta_mem[tail_ptr] <= push_meta;
         end
      end
   end

   // Sticky error flags and saturating mispredict statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow       <= 1'b0;
         underflow      <= 1'b0;
         mispredict_cnt <= '0;
      end else if (!stall) begin
         if (drop)
            overflow <= 1'b1;
         if (under)
            underflow <= 1'b1;
         if (mispredict && (mispredict_cnt != 16'hFFFF))
            mispredict_cnt <= mispredict_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Scoreboard bench for branch_resolution_queue: a queue-based reference model
// produces per-cycle expected outputs that a negedge monitor compares.
module tb_branch_resolution_queue;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned META_W = 2;
   localparam int unsigned CW     = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              stall;
   logic              push_valid;
   logic [ADDR_W-1:0] push_addr;
   logic              push_pred;
   logic [META_W-1:0] push_meta;
   logic              push_ready;
   logic              resolve_valid;
   logic              resolve_taken;
   logic              head_valid;
   logic [ADDR_W-1:0] head_addr;
   logic              head_pred;
   logic [META_W-1:0] head_meta;
   logic              mispredict;
   logic [CW-1:0]     count;
   logic              full;
   logic              empty;
   logic              overflow;
   logic              underflow;
   logic [15:0]       mispredict_cnt;

   branch_resolution_queue #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .META_W (META_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .push_valid     (push_valid),
      .push_addr      (push_addr),
      .push_pred      (push_pred),
      .push_meta      (push_meta),
      .push_ready     (push_ready),
      .resolve_valid  (resolve_valid),
      .resolve_taken  (resolve_taken),
      .head_valid     (head_valid),
      .head_addr      (head_addr),
      .head_pred      (head_pred),
      .head_meta      (head_meta),
      .mispredict     (mispredict),
      .count          (count),
      .full           (full),
      .empty          (empty),
      .overflow       (overflow),
      .underflow      (underflow),
      .mispredict_cnt (mispredict_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic              p;
      logic [META_W-1:0] m;
   } ent_t;

   typedef struct {
      logic              hv;
      logic [ADDR_W-1:0] ha;
      logic              hp;
      logic [META_W-1:0] hm;
      logic              mp;
      logic              pr;
      int                cnt;
      logic              fu;
      logic              em;
      logic              ov;
      logic              un;
      int                mc;
   } exp_t;

   ent_t mq[$];
   exp_t sb[$];
   bit   m_ovf;
   bit   m_unf;
   int   m_mc;

   int total = 0;
   int bad   = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
      m_mc  = 0;
   endtask

   // One clock cycle of stimulus; expectation computed from model, then model advanced.
   task automatic cyc(input logic st, input logic pv, input logic [ADDR_W-1:0] pa,
                      input logic pp, input logic [META_W-1:0] pm,
                      input logic rv, input logic rt);
      exp_t e;
      ent_t n;
      bit   emp, ful;
      @(posedge clk);
      #1;
      stall = st; push_valid = pv; push_addr = pa; push_pred = pp; push_meta = pm;
      resolve_valid = rv; resolve_taken = rt;
      emp   = (mq.size() == 0);
      ful   = (mq.size() == DEPTH);
      e.hv  = !emp;
      e.ha  = emp ? '0 : mq[0].a;
      e.hp  = emp ? 1'b0 : mq[0].p;
      e.hm  = emp ? '0 : mq[0].m;
      e.mp  = !st && rv && !emp && (rt != mq[0].p);
      e.pr  = !st && (!ful || (rv && !emp && !e.mp));
      e.cnt = mq.size();
      e.fu  = ful;
      e.em  = emp;
      e.ov  = m_ovf;
      e.un  = m_unf;
      e.mc  = m_mc;
      sb.push_back(e);
      if (!st) begin
         if (e.mp) begin
            mq.delete();
            if (m_mc < 16'hFFFF) m_mc++;
         end else begin
            if (rv && emp) m_unf = 1;
            if (rv && !emp) void'(mq.pop_front());
            if (pv && e.pr) begin
               n.a = pa; n.p = pp; n.m = pm;
               mq.push_back(n);
            end
            if (pv && !e.pr) m_ovf = 1;
         end
      end
   endtask

   // Monitor: compare every DUT output mid-cycle against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("head_valid", 32'(head_valid), 32'(e.hv));
         chk("head_addr", 32'(head_addr), 32'(e.ha));
         chk("head_pred", 32'(head_pred), 32'(e.hp));
         chk("head_meta", 32'(head_meta), 32'(e.hm));
         chk("mispredict", 32'(mispredict), 32'(e.mp));
         chk("push_ready", 32'(push_ready), 32'(e.pr));
         chk("count", 32'(count), 32'(e.cnt));
         chk("full", 32'(full), 32'(e.fu));
         chk("empty", 32'(empty), 32'(e.em));
         chk("overflow", 32'(overflow), 32'(e.ov));
         chk("underflow", 32'(underflow), 32'(e.un));
         chk("mispredict_cnt", 32'(mispredict_cnt), 32'(e.mc));
      end
   end

   task automatic idle_inputs();
      push_valid = 0; push_addr = '0; push_pred = 0; push_meta = '0;
      resolve_valid = 0; resolve_taken = 0;
   endtask

   task automatic chk_reset_state(string tag);
      chk({tag, "_count"}, 32'(count), 0);
      chk({tag, "_empty"}, 32'(empty), 1);
      chk({tag, "_full"}, 32'(full), 0);
      chk({tag, "_head_valid"}, 32'(head_valid), 0);
      chk({tag, "_head_addr"}, 32'(head_addr), 0);
      chk({tag, "_push_ready"}, 32'(push_ready), 0);
      chk({tag, "_overflow"}, 32'(overflow), 0);
      chk({tag, "_underflow"}, 32'(underflow), 0);
      chk({tag, "_mcnt"}, 32'(mispredict_cnt), 0);
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1;
      stall = 0;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic rt;
      rst_n = 0;
      stall = 1;
      idle_inputs();
      #1;
      chk_reset_state("por");
      release_reset();

      // fill to DEPTH, then overflow, then full pass-through
      for (int i = 0; i < 4; i++)
         cyc(0, 1, ADDR_W'(16'h1000 + i), 1, META_W'(i), 0, 0);
      cyc(0, 0, '0, 0, '0, 0, 0);
      cyc(0, 1, 16'h1004, 1, 2'd1, 0, 0);
      cyc(0, 0, '0, 0, '0, 0, 0);
      cyc(0, 1, 16'h2000, 1, 2'd3, 1, 1);
      for (int i = 0; i < 4; i++)
         cyc(0, 0, '0, 0, '0, 1, 1);

      // in-order pop across pointer wrap
      cyc(0, 1, 16'h3000, 1, 2'd0, 0, 0);
      for (int i = 1; i <= 6; i++)
         cyc(0, 1, ADDR_W'(16'h3000 + i), 1, META_W'(i), 1, 1);
      cyc(0, 0, '0, 0, '0, 1, 1);

      // push with resolve while empty: underflow, push accepted
      cyc(0, 1, 16'h4000, 1, 2'd2, 1, 1);
      cyc(0, 0, '0, 0, '0, 1, 1);
      cyc(0, 0, '0, 0, '0, 1, 0);

      // mispredict flush with same-cycle push
      for (int i = 0; i < 3; i++)
         cyc(0, 1, ADDR_W'(16'h5000 + i), 0, META_W'(i), 0, 0);
      cyc(0, 1, 16'h5555, 1, 2'd3, 1, 1);
      cyc(0, 0, '0, 0, '0, 0, 0);

      // stall freezes state despite push and resolve
      cyc(0, 1, 16'h6000, 1, 2'd1, 0, 0);
      cyc(0, 1, 16'h6001, 0, 2'd2, 0, 0);
      cyc(1, 1, 16'h6002, 1, 2'd3, 1, 0);
      cyc(1, 1, 16'h6003, 1, 2'd3, 1, 1);
      cyc(0, 0, '0, 0, '0, 0, 0);

      // randomized traffic, resolves mostly correct
      for (int i = 0; i < 600; i++) begin
         if (mq.size() > 0)
            rt = mq[0].p ^ ($urandom_range(0, 7) == 0);
         else
            rt = 1'($urandom);
         cyc(($urandom_range(0, 9) == 0), 1'($urandom), ADDR_W'($urandom),
             1'($urandom), META_W'($urandom), ($urandom_range(0, 2) == 0), rt);
      end

      // asynchronous reset mid-fill
      cyc(0, 1, 16'h7000, 1, 2'd0, 0, 0);
      cyc(0, 1, 16'h7001, 1, 2'd1, 0, 0);
      @(negedge clk);
      #1;
      idle_inputs();
      stall = 1;
      rst_n = 0;
      #1;
      chk_reset_state("async_rst");
      release_reset();
      for (int i = 0; i < 5; i++)
         cyc(0, 1, ADDR_W'(16'h8000 + i), 1, META_W'(i), 0, 0);
      for (int i = 0; i < 4; i++)
         cyc(0, 1, ADDR_W'(16'h8100 + i), 0, META_W'(i), 1, 1);
      for (int i = 0; i < 4; i++)
         cyc(0, 0, '0, 0, '0, 1, 0);
      cyc(0, 0, '0, 0, '0, 0, 0);

      @(negedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
